// File: rtl/p4_router_pkg.sv
// Shared types for the P4 router ingress blocks: arbiter FSM states and counter width.
package p4_router_pkg;

   typedef enum logic {ING_ARB_IDLE, ING_ARB_PKT} ing_arb_state_t;

   localparam int ING_ARB_CNT_WIDTH = 32;

endpackage

// File: rtl/p4_router_rr_pick.sv
// Combinational round-robin picker: first requester strictly after 'last', wrapping N-1 -> 0.
module p4_router_rr_pick #(
   parameter int N  = 11,
   parameter int LW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [LW-1:0] last,
   output logic          any,
   output logic [LW-1:0] idx
);

   logic [2*N-1:0] dbl;
   logic [2*N-1:0] win;

   // Doubling the request vector turns the wrap into a plain window last+1 .. last+N.
   always_comb begin
      dbl = {req, req};
      win = '0;
      for (int j = 0; j < 2*N; j++) begin
         win[j] = dbl[j] && (j > int'(last)) && (j <= int'(last) + N);
      end
   end

   always_comb begin
      any = |req;
      idx = '0;
      for (int j = 2*N-1; j >= 0; j--) begin
         if (win[j]) idx = (j >= N) ? LW'(j - N) : LW'(j);
      end
   end

endmodule

// File: rtl/p4_router_vnp4_ing_arb.sv
// Packet-granular round-robin arbiter feeding the VNP4 ingress stream; zero-latency data mux.
// Optional per-port packet counters enabled by P4_ROUTER_ING_ARB_PKT_COUNT_EN.
module p4_router_vnp4_ing_arb
   import p4_router_pkg::*;
#(
   parameter int NUM_PORTS         = 11,
   parameter int DATA_BYTES        = 8,
   parameter int ING_PORT_ID_WIDTH = 4
) (
   input  logic                                   clk,
   input  logic                                   areset,
   input  logic [NUM_PORTS*DATA_BYTES*8-1:0]      s_tdata,
   input  logic [NUM_PORTS*DATA_BYTES-1:0]        s_tkeep,
   input  logic [NUM_PORTS-1:0]                   s_tlast,
   input  logic [NUM_PORTS-1:0]                   s_tvalid,
   output logic [NUM_PORTS-1:0]                   s_tready,
   output logic [DATA_BYTES*8-1:0]                m_tdata,
   output logic [DATA_BYTES-1:0]                  m_tkeep,
   output logic                                   m_tlast,
   output logic                                   m_tvalid,
   input  logic                                   m_tready,
   output logic [ING_PORT_ID_WIDTH-1:0]           user_metadata_in_ing_port,
   output logic                                   user_metadata_in_valid,
   output logic [NUM_PORTS*ING_ARB_CNT_WIDTH-1:0] pkt_count
);

   localparam int GW = $clog2(NUM_PORTS);
   localparam int DW = DATA_BYTES * 8;

   if (NUM_PORTS < 2) begin : g_chk_min
      $error("NUM_PORTS must be at least 2");
   end
   if (NUM_PORTS > 2**ING_PORT_ID_WIDTH) begin : g_chk_max
      $error("NUM_PORTS does not fit in ING_PORT_ID_WIDTH");
   end
   if (DATA_BYTES < 1) begin : g_chk_db
      $error("DATA_BYTES must be positive");
   end

   ing_arb_state_t state, state_nxt;
   logic [GW-1:0]  grant, grant_nxt;
   logic [GW-1:0]  last_grant, last_grant_nxt;
   logic           first_beat, first_beat_nxt;
   logic           pick_any;
   logic [GW-1:0]  pick_idx;
   logic           hs;

   p4_router_rr_pick #(.N(NUM_PORTS), .LW(GW)) u_pick (
      .req  (s_tvalid),
      .last (last_grant),
      .any  (pick_any),
      .idx  (pick_idx)
   );

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state      <= ING_ARB_IDLE;
         grant      <= '0;
         last_grant <= GW'(NUM_PORTS - 1);
         first_beat <= 1'b1;
      end else begin
         state      <= state_nxt;
         grant      <= grant_nxt;
         last_grant <= last_grant_nxt;
         first_beat <= first_beat_nxt;
      end
   end

   assign hs = m_tvalid & m_tready;

   always_comb begin
      state_nxt      = state;
      grant_nxt      = grant;
      last_grant_nxt = last_grant;
      first_beat_nxt = first_beat;
      case (state)
         ING_ARB_IDLE: begin
            if (pick_any) begin
               grant_nxt = pick_idx;
               state_nxt = ING_ARB_PKT;
            end
         end
         ING_ARB_PKT: begin
            if (hs && m_tlast) begin
               last_grant_nxt = grant;
               first_beat_nxt = 1'b1;
               state_nxt      = ING_ARB_IDLE;
            end else if (hs) begin
               first_beat_nxt = 1'b0;
            end
         end
         default: state_nxt = ING_ARB_IDLE;
      endcase
   end

   // Outputs are forced to zero outside PKT so nothing leaks while idle or in reset.
   always_comb begin
      m_tdata  = '0;
      m_tkeep  = '0;
      m_tlast  = 1'b0;
      m_tvalid = 1'b0;
      s_tready = '0;
      if (state == ING_ARB_PKT) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant == GW'(i)) begin
               m_tdata     = s_tdata[i*DW +: DW];
               m_tkeep     = s_tkeep[i*DATA_BYTES +: DATA_BYTES];
               m_tlast     = s_tlast[i];
               m_tvalid    = s_tvalid[i];
               s_tready[i] = m_tready;
            end
         end
      end
   end

   assign user_metadata_in_ing_port = ING_PORT_ID_WIDTH'(grant);
   assign user_metadata_in_valid    = (state == ING_ARB_PKT) & m_tvalid & first_beat;

`ifdef P4_ROUTER_ING_ARB_PKT_COUNT_EN
   logic [NUM_PORTS-1:0][ING_ARB_CNT_WIDTH-1:0] cnt;

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         cnt <= '0;
      end else if (hs && m_tlast) begin
         cnt[grant] <= cnt[grant] + 1'b1;
      end
   end

   assign pkt_count = cnt;
`else
   assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_p4_router_vnp4_ing_arb.sv
// Directed bench for the VNP4 ingress arbiter: table of single-port packets plus hand sequences.
module tb_p4_router_vnp4_ing_arb;

   localparam int N  = 11;
   localparam int DB = 8;
   localparam int IW = 4;
   localparam int CW = 32;
`ifdef P4_ROUTER_ING_ARB_PKT_COUNT_EN
   localparam int CNT_EN = 1;
`else
   localparam int CNT_EN = 0;
`endif

   logic              clk = 1'b0;
   logic              areset = 1'b1;
   logic [N*DB*8-1:0] s_tdata = '0;
   logic [N*DB-1:0]   s_tkeep = '0;
   logic [N-1:0]      s_tlast = '0;
   logic [N-1:0]      s_tvalid = '0;
   logic [N-1:0]      s_tready;
   logic [DB*8-1:0]   m_tdata;
   logic [DB-1:0]     m_tkeep;
   logic              m_tlast;
   logic              m_tvalid;
   logic              m_tready = 1'b1;
   logic [IW-1:0]     ing_port;
   logic              md_valid;
   logic [N*CW-1:0]   pkt_count;

   int checks = 0;
   int errors = 0;

   p4_router_vnp4_ing_arb #(.NUM_PORTS(N), .DATA_BYTES(DB), .ING_PORT_ID_WIDTH(IW)) dut (
      .clk                       (clk),
      .areset                    (areset),
      .s_tdata                   (s_tdata),
      .s_tkeep                   (s_tkeep),
      .s_tlast                   (s_tlast),
      .s_tvalid                  (s_tvalid),
      .s_tready                  (s_tready),
      .m_tdata                   (m_tdata),
      .m_tkeep                   (m_tkeep),
      .m_tlast                   (m_tlast),
      .m_tvalid                  (m_tvalid),
      .m_tready                  (m_tready),
      .user_metadata_in_ing_port (ing_port),
      .user_metadata_in_valid    (md_valid),
      .pkt_count                 (pkt_count)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] dval(input int p, input int b);
      return {24'hC0FFEE, 8'(p), 24'h5A5A00, 8'(b)};
   endfunction

   function automatic logic [7:0] kval(input int p, input int b);
      return 8'((p << 4) | (b & 15));
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive_beat(input int p, input int b, input bit last);
      s_tdata[p*64 +: 64] = dval(p, b);
      s_tkeep[p*8 +: 8]   = kval(p, b);
      s_tlast[p]          = last;
      s_tvalid[p]         = 1'b1;
   endtask

   task automatic clear_port(input int p);
      s_tvalid[p] = 1'b0;
      s_tlast[p]  = 1'b0;
   endtask

   task automatic check_out(input string nm, input bit vld, input int p, input int b,
                            input bit last, input bit mdv, input logic [N-1:0] rdy);
      chk({nm, ".vld"}, 64'(m_tvalid), 64'(vld));
      chk({nm, ".s_tready"}, 64'(s_tready), 64'(rdy));
      chk({nm, ".md_valid"}, 64'(md_valid), 64'(mdv));
      if (vld) begin
         chk({nm, ".data"}, m_tdata, dval(p, b));
         chk({nm, ".keep"}, 64'(m_tkeep), 64'(kval(p, b)));
         chk({nm, ".last"}, 64'(m_tlast), 64'(last));
         chk({nm, ".ing_port"}, 64'(ing_port), 64'(p));
      end
   endtask

   task automatic check_zero(input string nm);
      chk({nm, ".vld"}, 64'(m_tvalid), 64'd0);
      chk({nm, ".s_tready"}, 64'(s_tready), 64'd0);
      chk({nm, ".md_valid"}, 64'(md_valid), 64'd0);
      chk({nm, ".ing_port"}, 64'(ing_port), 64'd0);
      chk({nm, ".data"}, m_tdata, 64'd0);
      chk({nm, ".keep"}, 64'(m_tkeep), 64'd0);
      chk({nm, ".last"}, 64'(m_tlast), 64'd0);
      chk({nm, ".pkt_count"}, 64'(|pkt_count), 64'd0);
   endtask

   // Sends one packet from port p while no other port requests; mode picks m_tready pattern.
   task automatic send_pkt(input int p, input int n, input int mode, input int exp_port,
                           output int beats_out);
      int b = 0;
      int cyc = 0;
      bit r;
      beats_out = 0;
      @(negedge clk);
      drive_beat(p, 0, n == 1);
      m_tready = 1'b1;
      #1 check_out("grant_wait", 1'b0, p, 0, 1'b0, 1'b0, '0);
      while (b < n && cyc < 40) begin
         @(negedge clk);
         drive_beat(p, b, b == n-1);
         r = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : (cyc % 2 == 1);
         m_tready = r;
         #1 check_out("pkt", 1'b1, exp_port, b, b == n-1, b == 0, N'(r) << exp_port);
         if (m_tvalid && r) begin
            b++;
            beats_out++;
         end
         cyc++;
      end
      if (cyc >= 40) chk("pkt_timeout", 64'(cyc), 64'(n));
      @(negedge clk);
      clear_port(p);
      m_tready = 1'b1;
   endtask

   typedef struct {
      int port;
      int beats;
      int mode;
      int exp_port;
      int exp_beats;
   } vec_t;

   vec_t vecs[4];
   int   bi[N];
   int   nb;

   initial begin
      vecs[0] = '{port: 3, beats: 4, mode: 0, exp_port: 3, exp_beats: 4};
      vecs[1] = '{port: 7, beats: 5, mode: 1, exp_port: 7, exp_beats: 5};
      vecs[2] = '{port: 6, beats: 3, mode: 2, exp_port: 6, exp_beats: 3};
      vecs[3] = '{port: 9, beats: 1, mode: 0, exp_port: 9, exp_beats: 1};

      #2 check_zero("reset");
      @(negedge clk);
      areset = 1'b0;

      foreach (vecs[i]) begin
         send_pkt(vecs[i].port, vecs[i].beats, vecs[i].mode, vecs[i].exp_port, nb);
         chk($sformatf("vec%0d.beats", i), 64'(nb), 64'(vecs[i].exp_beats));
      end

      // All ports request 2-beat packets: idle, beat0, beat1 per port in order 0..10.
      @(negedge clk);
      areset = 1'b1;
      #1 areset = 1'b0;
      for (int p = 0; p < N; p++) bi[p] = 0;
      for (int c = 0; c < 3*N; c++) begin
         @(negedge clk);
         for (int p = 0; p < N; p++) begin
            if (bi[p] < 2) drive_beat(p, bi[p], bi[p] == 1);
            else clear_port(p);
         end
         #1;
         if (c % 3 == 0)
            check_out($sformatf("rr%0d.idle", c/3), 1'b0, 0, 0, 1'b0, 1'b0, '0);
         else
            check_out($sformatf("rr%0d", c/3), 1'b1, c/3, c%3 - 1, c%3 == 2, c%3 == 1,
                      N'(1) << (c/3));
         for (int p = 0; p < N; p++) if (s_tvalid[p] && s_tready[p]) bi[p]++;
      end
      @(negedge clk);
      for (int p = 0; p < N; p++) clear_port(p);

      // Port 2 stalls mid-packet while port 5 requests.
      @(negedge clk);
      drive_beat(2, 0, 1'b0);
      #1 check_out("stall.idle", 1'b0, 2, 0, 1'b0, 1'b0, '0);
      @(negedge clk);
      #1 check_out("stall.b0", 1'b1, 2, 0, 1'b0, 1'b1, N'(1) << 2);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         clear_port(2);
         drive_beat(5, 0, 1'b1);
         #1 check_out("stall.hold", 1'b0, 2, 0, 1'b0, 1'b0, N'(1) << 2);
         chk("stall.ing_port", 64'(ing_port), 64'd2);
      end
      for (int b = 1; b < 3; b++) begin
         @(negedge clk);
         drive_beat(2, b, b == 2);
         #1 check_out("stall.rest", 1'b1, 2, b, b == 2, 1'b0, N'(1) << 2);
      end
      @(negedge clk);
      clear_port(2);
      #1 check_out("stall.gap", 1'b0, 0, 0, 1'b0, 1'b0, '0);
      @(negedge clk);
      #1 check_out("stall.p5", 1'b1, 5, 0, 1'b1, 1'b1, N'(1) << 5);
      @(negedge clk);
      clear_port(5);

      // Single-beat packets from 10 and 0: wrap after 10.
      drive_beat(10, 0, 1'b1);
      drive_beat(0, 0, 1'b1);
      #1 check_out("wrap.idle", 1'b0, 0, 0, 1'b0, 1'b0, '0);
      @(negedge clk);
      #1 check_out("wrap.p10", 1'b1, 10, 0, 1'b1, 1'b1, N'(1) << 10);
      @(negedge clk);
      clear_port(10);
      #1 check_out("wrap.gap", 1'b0, 0, 0, 1'b0, 1'b0, '0);
      @(negedge clk);
      #1 check_out("wrap.p0", 1'b1, 0, 0, 1'b1, 1'b1, N'(1));
      @(negedge clk);
      clear_port(0);

      // Reset mid-packet from port 7.
      drive_beat(7, 0, 1'b0);
      @(negedge clk);
      #1 check_out("rst.b0", 1'b1, 7, 0, 1'b0, 1'b1, N'(1) << 7);
      @(negedge clk);
      drive_beat(7, 1, 1'b0);
      #1 check_out("rst.b1", 1'b1, 7, 1, 1'b0, 1'b0, N'(1) << 7);
      areset = 1'b1;
      #1 check_zero("rst.mid");
      clear_port(7);
      @(negedge clk);
      areset = 1'b0;
      drive_beat(8, 0, 1'b1);
      drive_beat(1, 0, 1'b1);
      #1 check_out("rst.idle", 1'b0, 0, 0, 1'b0, 1'b0, '0);
      @(negedge clk);
      #1 check_out("rst.p1", 1'b1, 1, 0, 1'b1, 1'b1, N'(1) << 1);
      @(negedge clk);
      clear_port(1);
      #1 check_out("rst.gap", 1'b0, 0, 0, 1'b0, 1'b0, '0);
      @(negedge clk);
      #1 check_out("rst.p8", 1'b1, 8, 0, 1'b1, 1'b1, N'(1) << 8);
      @(negedge clk);
      clear_port(8);
      send_pkt(1, 2, 0, 1, nb);
      send_pkt(1, 3, 1, 1, nb);
      #1;
      chk("cnt.p1", 64'(pkt_count[1*CW +: CW]), 64'(3 * CNT_EN));
      chk("cnt.p8", 64'(pkt_count[8*CW +: CW]), 64'(1 * CNT_EN));
      chk("cnt.p7", 64'(pkt_count[7*CW +: CW]), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
